// File: rtl/gate_sweep_checker_if.sv
// Stimulus/result bundle between a gate sweep checker (slave) and whatever drives
// start/mode and hosts the gate under test (master).
interface gate_sweep_checker_if #(
  parameter int N_IN  = 2,
  parameter int CNT_W = 8
);
  logic              start;
  logic [2:0]        mode;
  logic              dut_y;
  logic [N_IN-1:0]   stim;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  err_count;
  logic [N_IN-1:0]   first_fail;
  logic              first_fail_vld;

  modport master (
    output start, mode, dut_y,
    input  stim, busy, done, pass, err_count, first_fail, first_fail_vld
  );

  modport slave (
    input  start, mode, dut_y,
    output stim, busy, done, pass, err_count, first_fail, first_fail_vld
  );
endinterface

// File: rtl/gate_sweep_checker.sv
// Sweeps every input vector into an external gate, compares its output to a golden
// function and reports mismatches. GATE_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module gate_sweep_checker #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  gate_sweep_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  // With no settle time each vector goes straight to the compare cycle.
  localparam state_t           VEC_STATE   = (SETTLE == 0) ? SAMPLE : WAIT;
  localparam logic [3:0]       SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  localparam logic [CNT_W-1:0] ERR_MAX     = '1;
  localparam logic [CNT_W-1:0] ERR_ONE     = CNT_W'(1);
  localparam logic [N_IN-1:0]  STIM_ONE    = N_IN'(1);

  state_t           state;
  logic [2:0]       mode_q;
  logic [3:0]       settle_cnt;
  logic             golden;
  logic             mismatch;
  logic [CNT_W-1:0] err_nxt;

  always_comb begin
    golden = 1'b0;
    case (mode_q)
      3'b000:  golden = &bus.stim;
      3'b001:  golden = |bus.stim;
      3'b010:  golden = ~&bus.stim;
      3'b011:  golden = ~|bus.stim;
      3'b100:  golden = ^bus.stim;
      3'b101:  golden = ~^bus.stim;
      3'b110:  golden = bus.stim[0];
      default: golden = ~bus.stim[0];
    endcase
  end

  assign mismatch = (bus.dut_y != golden);
  assign err_nxt  = (mismatch && (bus.err_count != ERR_MAX)) ? bus.err_count + ERR_ONE
                                                              : bus.err_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      mode_q             <= 3'b000;
      settle_cnt         <= 4'd0;
      bus.stim           <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.pass           <= 1'b0;
      bus.err_count      <= '0;
      bus.first_fail     <= '0;
      bus.first_fail_vld <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mode_q             <= bus.mode;
            settle_cnt         <= 4'd0;
            bus.stim           <= '0;
            bus.err_count      <= '0;
            bus.first_fail     <= '0;
            bus.first_fail_vld <= 1'b0;
            bus.busy           <= 1'b1;
            state              <= VEC_STATE;
          end
        end
        WAIT: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= 4'd0;
            state      <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        SAMPLE: begin
          bus.err_count <= err_nxt;
          if (mismatch && !bus.first_fail_vld) begin
            bus.first_fail     <= bus.stim;
            bus.first_fail_vld <= 1'b1;
          end
          // pass uses the post-compare count so it is valid alongside done.
          if ((bus.stim == '1) || (STOP_ON_FAIL && mismatch)) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= (err_nxt == '0);
            state    <= DONE;
          end else begin
            bus.stim <= bus.stim + STIM_ONE;
            state    <= VEC_STATE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench: two checker instances (N_IN=2/SETTLE=1/CNT_W=8 and N_IN=3/SETTLE=0/CNT_W=2)
// driven with directed sweeps; expected results are queued at start and checked on done.
module tb_gate_sweep_checker;

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  typedef struct {
    int t0;
    int lat;
    int err;
    int pass;
    int ff;
    int ffv;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   beh_a = 0;
  int   beh_b = 0;
  int   t0_a = 0;
  int   t0_b = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  gate_sweep_checker_if #(.N_IN(2), .CNT_W(8)) bus_a ();
  gate_sweep_checker_if #(.N_IN(3), .CNT_W(2)) bus_b ();

  gate_sweep_checker #(.N_IN(2), .SETTLE(1), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  gate_sweep_checker #(.N_IN(3), .SETTLE(0), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Lab gate models: A is NAND / AND / tied-1 / NOR, B is XOR / XNOR.
  function automatic logic model_a(input int b, input logic [1:0] s);
    case (b)
      0:       return ~&s;
      1:       return &s;
      2:       return 1'b1;
      default: return ~|s;
    endcase
  endfunction

  assign bus_a.dut_y = model_a(beh_a, bus_a.stim);
  assign bus_b.dut_y = (beh_b == 0) ? ^bus_b.stim : ~^bus_b.stim;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_a"}, {bus_a.stim, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count,
                       bus_a.first_fail, bus_a.first_fail_vld}, 32'd0);
    chk({name, "_b"}, {bus_b.stim, bus_b.busy, bus_b.done, bus_b.pass, bus_b.err_count,
                       bus_b.first_fail, bus_b.first_fail_vld}, 32'd0);
  endtask

  // Monitors: pop and compare on every done pulse, and track the stim stepping while busy.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (bus_a.busy) chk("stim_step_a", bus_a.stim, (cyc - t0_a) / 2);
    if (bus_a.done) begin
      if (q_a.size() == 0) chk("unexpected_done_a", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("done_latency_a", cyc - e.t0, e.lat);
        chk("err_count_a", bus_a.err_count, e.err);
        chk("pass_a", bus_a.pass, e.pass);
        chk("first_fail_vld_a", bus_a.first_fail_vld, e.ffv);
        chk("first_fail_a", bus_a.first_fail, e.ff);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (bus_b.busy) chk("stim_step_b", bus_b.stim, cyc - t0_b);
    if (bus_b.done) begin
      if (q_b.size() == 0) chk("unexpected_done_b", 1, 0);
      else begin
        e = q_b.pop_front();
        chk("done_latency_b", cyc - e.t0, e.lat);
        chk("err_count_b", bus_b.err_count, e.err);
        chk("pass_b", bus_b.pass, e.pass);
        chk("first_fail_vld_b", bus_b.first_fail_vld, e.ffv);
        chk("first_fail_b", bus_b.first_fail, e.ff);
      end
    end
  end

  task automatic start_a(input logic [2:0] m, input int b, input int lat, input int err,
                         input int pass, input int ff, input int ffv, input bit hold);
    exp_t e;
    @(negedge clk);
    bus_a.mode  = m;
    beh_a       = b;
    bus_a.start = 1'b1;
    t0_a        = cyc + 1;
    e = '{t0: cyc + 1, lat: lat, err: err, pass: pass, ff: ff, ffv: ffv};
    q_a.push_back(e);
    if (!hold) begin
      @(negedge clk);
      bus_a.start = 1'b0;
    end
  endtask

  task automatic start_b(input int b, input int lat, input int err, input int pass,
                         input int ff, input int ffv);
    exp_t e;
    @(negedge clk);
    bus_b.mode  = 3'b100;
    beh_b       = b;
    bus_b.start = 1'b1;
    t0_b        = cyc + 1;
    e = '{t0: cyc + 1, lat: lat, err: err, pass: pass, ff: ff, ffv: ffv};
    q_b.push_back(e);
    @(negedge clk);
    bus_b.start = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
    chk({name, "_drained"}, q_a.size() + q_b.size(), 0);
    q_a.delete();
    q_b.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bus_a.start = 1'b0;
    bus_a.mode  = 3'b000;
    bus_b.start = 1'b0;
    bus_b.mode  = 3'b000;
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Ideal NAND against NAND golden: clean sweep, 4 vectors x 2 cycles.
    start_a(3'b010, 0, 8, 0, 1, 0, 0, 1'b0);
    drain("nand_ideal");

    // Reset during WAIT clears everything, including the held pass.
    start_a(3'b010, 0, 8, 0, 1, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("mid_wait_busy", bus_a.busy, 1);
    #2 rst = 1'b1;
    q_a.delete();
    #1;
    chk_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    start_a(3'b011, 3, 8, 0, 1, 0, 0, 1'b0);
    drain("after_reset_nor");

    // AND gate against NAND golden: every vector mismatches.
    start_a(3'b010, 1, STOP ? 2 : 8, STOP ? 1 : 4, 0, 0, 1, 1'b0);
    drain("nand_vs_and");

    // Output stuck at 1: only vector 11 mismatches.
    start_a(3'b010, 2, 8, 1, 0, 3, 1, 1'b0);
    drain("nand_stuck1");

    // Three-input XOR, no settle: clean, then inverted gate saturating a 2-bit counter.
    start_b(0, 8, 0, 1, 0, 0);
    drain("xor_ideal");
    start_b(1, STOP ? 1 : 8, STOP ? 1 : 3, 0, 0, 1);
    drain("xor_saturate");

    // start held and mode toggled mid-sweep: AND golden stays latched, one done only.
    start_a(3'b000, 1, 8, 0, 1, 0, 0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus_a.mode = (i % 2 == 0) ? 3'b111 : 3'b001;
    end
    bus_a.start = 1'b0;
    drain("start_held");
    chk("held_no_restart_busy", bus_a.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
